wb_arbiter: RTL and testbench

- Two-master to one-slave Wishbone arbiter placed between the CPU bus users and the external bus.
- Master 0 is the instruction fetcher; master 1 is the load/store (data) path.
- Grants are registered. Once granted, the bus stays locked to that master for its whole cycle (cyc high) and is re-arbitrated only after release.
- The block replaces the direct fetcher-to-bus wiring in the CPU top level.

---
 rtl/wb_arbiter.sv | 138 +++++++++++++
 tb/tb_wb_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Two-master to one-slave Wishbone arbiter: registered grants, bus locked to the owner while its cyc is high.
// Define WB_ARB_TIMEOUT_EN to add a stall watchdog that errors out and releases a hung cycle.
module wb_arbiter #(
    parameter int ROUND_ROBIN    = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_reset_n,

    input  logic [31:0] i_m0_addr,
    input  logic        i_m0_cyc,
    input  logic [3:0]  i_m0_stb,
    input  logic        i_m0_we,
    input  logic [31:0] i_m0_dat,
    output logic [31:0] o_m0_dat,
    output logic        o_m0_ack,
    output logic        o_m0_err,
    output logic        o_m0_gnt,

    input  logic [31:0] i_m1_addr,
    input  logic        i_m1_cyc,
    input  logic [3:0]  i_m1_stb,
    input  logic        i_m1_we,
    input  logic [31:0] i_m1_dat,
    output logic [31:0] o_m1_dat,
    output logic        o_m1_ack,
    output logic        o_m1_err,
    output logic        o_m1_gnt,

    output logic [31:0] o_wb_addr,
    output logic        o_wb_cyc,
    output logic [3:0]  o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_dat,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_ack,
    input  logic        i_wb_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state;
    logic   last_m1;
    logic   timeout;

`ifdef WB_ARB_TIMEOUT_EN
    logic [15:0] stall_cnt;

    assign timeout = (state != IDLE) && (stall_cnt == 16'(TIMEOUT_CYCLES));

    // Counts only cycles where the owner is strobing and the slave stays silent.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            stall_cnt <= '0;
        end else if (state == IDLE || i_wb_ack || i_wb_err) begin
            stall_cnt <= '0;
        end else if (o_wb_stb != 4'h0) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`else
    // Without the watchdog the limit is irrelevant; the term is constant zero.
    assign timeout = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state   <= IDLE;
            last_m1 <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (i_m0_cyc && i_m1_cyc) begin
                        if (ROUND_ROBIN != 0 && last_m1) begin
                            state   <= GNT0;
                            last_m1 <= 1'b0;
                        end else begin
                            state   <= GNT1;
                            last_m1 <= 1'b1;
                        end
                    end else if (i_m0_cyc) begin
                        state   <= GNT0;
                        last_m1 <= 1'b0;
                    end else if (i_m1_cyc) begin
                        state   <= GNT1;
                        last_m1 <= 1'b1;
                    end
                end
                GNT0:    if (timeout || !i_m0_cyc) state <= IDLE;
                GNT1:    if (timeout || !i_m1_cyc) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default first so the combinational mux never infers a latch.
    always_comb begin
        o_wb_addr = '0;
        o_wb_cyc  = 1'b0;
        o_wb_stb  = 4'h0;
        o_wb_we   = 1'b0;
        o_wb_dat  = '0;
        case (state)
            GNT0: begin
                o_wb_addr = i_m0_addr;
                o_wb_cyc  = i_m0_cyc & ~timeout;
                o_wb_stb  = timeout ? 4'h0 : i_m0_stb;
                o_wb_we   = i_m0_we;
                o_wb_dat  = i_m0_dat;
            end
            GNT1: begin
                o_wb_addr = i_m1_addr;
                o_wb_cyc  = i_m1_cyc & ~timeout;
                o_wb_stb  = timeout ? 4'h0 : i_m1_stb;
                o_wb_we   = i_m1_we;
                o_wb_dat  = i_m1_dat;
            end
            default: ;
        endcase
    end

    assign o_m0_gnt = (state == GNT0);
    assign o_m1_gnt = (state == GNT1);

    assign o_m0_dat = i_wb_dat;
    assign o_m1_dat = i_wb_dat;

    assign o_m0_ack = i_wb_ack & o_m0_gnt;
    assign o_m1_ack = i_wb_ack & o_m1_gnt;
    assign o_m0_err = (i_wb_err | timeout) & o_m0_gnt;
    assign o_m1_err = (i_wb_err | timeout) & o_m1_gnt;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: a round-robin and a fixed-priority instance share stimulus and are
// checked every cycle against an ownership-level reference model.
module tb_wb_arbiter;

    localparam int TO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] m_addr [2];
    logic        m_cyc  [2];
    logic [3:0]  m_stb  [2];
    logic        m_we   [2];
    logic [31:0] m_dat  [2];
    logic [31:0] wb_rdat;
    logic        wb_ack;
    logic        wb_err;

    // Outputs, indexed by instance: 0 = round robin, 1 = fixed priority.
    logic [31:0] d0 [2], d1 [2];
    logic        ack0 [2], ack1 [2], err0 [2], err1 [2], gnt0 [2], gnt1 [2];
    logic [31:0] wa [2], wd [2];
    logic        wc [2], ww [2];
    logic [3:0]  ws [2];

    for (genvar k = 0; k < 2; k++) begin : g_dut
        wb_arbiter #(
            .ROUND_ROBIN   (k == 0 ? 1 : 0),
            .TIMEOUT_CYCLES(TO)
        ) dut (
            .i_clk    (clk),
            .i_reset_n(rst_n),
            .i_m0_addr(m_addr[0]),
            .i_m0_cyc (m_cyc[0]),
            .i_m0_stb (m_stb[0]),
            .i_m0_we  (m_we[0]),
            .i_m0_dat (m_dat[0]),
            .o_m0_dat (d0[k]),
            .o_m0_ack (ack0[k]),
            .o_m0_err (err0[k]),
            .o_m0_gnt (gnt0[k]),
            .i_m1_addr(m_addr[1]),
            .i_m1_cyc (m_cyc[1]),
            .i_m1_stb (m_stb[1]),
            .i_m1_we  (m_we[1]),
            .i_m1_dat (m_dat[1]),
            .o_m1_dat (d1[k]),
            .o_m1_ack (ack1[k]),
            .o_m1_err (err1[k]),
            .o_m1_gnt (gnt1[k]),
            .o_wb_addr(wa[k]),
            .o_wb_cyc (wc[k]),
            .o_wb_stb (ws[k]),
            .o_wb_we  (ww[k]),
            .o_wb_dat (wd[k]),
            .i_wb_dat (wb_rdat),
            .i_wb_ack (wb_ack),
            .i_wb_err (wb_err)
        );
    end

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: who owns the bus (-1 = nobody), who was granted last, stalled-cycle count.
    int own  [2];
    int last [2];
    int cnt  [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            own[k]  = -1;
            last[k] = 1;
            cnt[k]  = 0;
        end
    endtask

    function automatic bit model_to(input int k);
`ifdef WB_ARB_TIMEOUT_EN
        return (own[k] >= 0) && (cnt[k] == TO);
`else
        return (k < 0);
`endif
    endfunction

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            int          o;
            bit          to;
            logic        e_cyc, e_we;
            logic [3:0]  e_stb;
            logic [31:0] e_addr, e_dat;
            o      = own[k];
            to     = model_to(k);
            e_cyc  = (o >= 0 && !to) ? m_cyc[o] : 1'b0;
            e_stb  = (o >= 0 && !to) ? m_stb[o] : 4'h0;
            e_addr = (o >= 0) ? m_addr[o] : 32'h0;
            e_we   = (o >= 0) ? m_we[o] : 1'b0;
            e_dat  = (o >= 0) ? m_dat[o] : 32'h0;
            check($sformatf("wb_cyc[%0d]", k), wc[k], e_cyc);
            check($sformatf("wb_stb[%0d]", k), ws[k], e_stb);
            check($sformatf("wb_addr[%0d]", k), wa[k], e_addr);
            check($sformatf("wb_we[%0d]", k), ww[k], e_we);
            check($sformatf("wb_dat[%0d]", k), wd[k], e_dat);
            check($sformatf("m0_dat[%0d]", k), d0[k], wb_rdat);
            check($sformatf("m1_dat[%0d]", k), d1[k], wb_rdat);
            check($sformatf("m0_gnt[%0d]", k), gnt0[k], o == 0);
            check($sformatf("m1_gnt[%0d]", k), gnt1[k], o == 1);
            check($sformatf("m0_ack[%0d]", k), ack0[k], wb_ack && o == 0);
            check($sformatf("m1_ack[%0d]", k), ack1[k], wb_ack && o == 1);
            check($sformatf("m0_err[%0d]", k), err0[k], (wb_err || to) && o == 0);
            check($sformatf("m1_err[%0d]", k), err1[k], (wb_err || to) && o == 1);
        end
    endtask

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                own[k]  = -1;
                last[k] = 1;
                cnt[k]  = 0;
            end else if (own[k] < 0) begin
                int p;
                p = -1;
                if (m_cyc[0] && m_cyc[1]) p = (k == 0) ? 1 - last[k] : 1;
                else if (m_cyc[0])        p = 0;
                else if (m_cyc[1])        p = 1;
                if (p >= 0) begin
                    own[k]  = p;
                    last[k] = p;
                    cnt[k]  = 0;
                end
            end else if (model_to(k) || !m_cyc[own[k]]) begin
                own[k] = -1;
            end else if (wb_ack || wb_err) begin
                cnt[k] = 0;
            end else if (m_stb[own[k]] != 4'h0) begin
                cnt[k]++;
            end
        end
    endtask

    // Called at a falling edge after inputs are set: check, cross one rising edge, land on the next falling edge.
    task automatic tick();
        #1;
        compare_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic quiet_inputs();
        for (int j = 0; j < 2; j++) begin
            m_cyc[j]  = 1'b0;
            m_stb[j]  = 4'h0;
            m_we[j]   = 1'b0;
            m_addr[j] = 32'h0;
            m_dat[j]  = 32'h0;
        end
        wb_ack = 1'b0;
        wb_err = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drive_random();
        for (int j = 0; j < 2; j++) begin
            if (m_cyc[j]) begin
                if ($urandom_range(0, 5) == 0) m_cyc[j] = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                m_cyc[j] = 1'b1;
            end
            m_stb[j]  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            m_we[j]   = 1'($urandom);
            m_addr[j] = $urandom;
            m_dat[j]  = $urandom;
        end
        wb_rdat = $urandom;
        wb_ack  = ($urandom_range(0, 2) == 0);
        wb_err  = ($urandom_range(0, 15) == 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst_n   = 1'b0;
        wb_rdat = 32'hDEAD_BEEF;
        quiet_inputs();
        model_reset();

        // Reset state.
        #3;
        compare_all();
        for (int k = 0; k < 2; k++) check($sformatf("rst_cyc[%0d]", k), wc[k], 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // m0 alone: grant one cycle after request, ack passed through in cycle 3 only.
        m_cyc[0]  = 1'b1;
        m_stb[0]  = 4'hF;
        m_addr[0] = 32'h100;
        m_dat[0]  = 32'h1234_5678;
        tick();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("alone_gnt0[%0d]", k), gnt0[k], 1'b1);
            check($sformatf("alone_addr[%0d]", k), wa[k], 32'h100);
        end
        tick();
        tick();
        wb_ack = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("alone_ack0[%0d]", k), ack0[k], 1'b1);
            check($sformatf("alone_ack1[%0d]", k), ack1[k], 1'b0);
        end
        tick();
        wb_ack = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) check($sformatf("alone_ack0_off[%0d]", k), ack0[k], 1'b0);
        m_cyc[0] = 1'b0;
        tick();

        // Contention from reset: round robin alternates 0,1,0,1; fixed priority always picks m1.
        do_reset();
        for (int r = 0; r < 4; r++) begin
            m_cyc[0]  = 1'b1;
            m_cyc[1]  = 1'b1;
            m_stb[0]  = 4'hF;
            m_stb[1]  = 4'h3;
            m_addr[0] = 32'h200 + 32'(r);
            m_addr[1] = 32'h300 + 32'(r);
            tick();
            check($sformatf("rr_gnt0_r%0d", r), gnt0[0], (r % 2) == 0);
            check($sformatf("rr_gnt1_r%0d", r), gnt1[0], (r % 2) == 1);
            check($sformatf("fx_gnt1_r%0d", r), gnt1[1], 1'b1);
            check($sformatf("fx_gnt0_r%0d", r), gnt0[1], 1'b0);
            wb_ack = 1'b1;
            tick();
            wb_ack   = 1'b0;
            m_cyc[0] = 1'b0;
            m_cyc[1] = 1'b0;
            tick();
            check($sformatf("rr_idle_r%0d", r), {gnt0[0], gnt1[0]}, 2'b00);
        end

        // Lock: m1 holds the bus through a burst while m0 waits.
        m_cyc[1]  = 1'b1;
        m_stb[1]  = 4'hC;
        m_addr[1] = 32'h400;
        tick();
        m_cyc[0] = 1'b1;
        m_stb[0] = 4'hF;
        for (int i = 0; i < 6; i++) begin
            wb_ack    = 1'(i % 2);
            m_addr[1] = 32'h400 + 32'(4 * i);
            tick();
            for (int k = 0; k < 2; k++) begin
                check($sformatf("lock_cyc[%0d]_%0d", k, i), wc[k], 1'b1);
                check($sformatf("lock_gnt1[%0d]_%0d", k, i), gnt1[k], 1'b1);
            end
        end
        wb_ack   = 1'b0;
        m_cyc[1] = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) check($sformatf("lock_gap[%0d]", k), {gnt0[k], gnt1[k]}, 2'b00);
        tick();
        for (int k = 0; k < 2; k++) check($sformatf("lock_next_gnt0[%0d]", k), gnt0[k], 1'b1);
        m_cyc[0] = 1'b0;
        tick();

        // Asynchronous reset between edges while in GNT1.
        m_cyc[1] = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) check($sformatf("ar_pre_gnt1[%0d]", k), gnt1[k], 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("ar_cyc[%0d]", k), wc[k], 1'b0);
            check($sformatf("ar_gnt1[%0d]", k), gnt1[k], 1'b0);
        end
        model_reset();
        compare_all();
        @(posedge clk);
        @(negedge clk);
        m_cyc[1] = 1'b0;
        rst_n    = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 2; k++) check($sformatf("ar_stay_idle[%0d]", k), {gnt0[k], gnt1[k]}, 2'b00);
        m_cyc[1] = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) check($sformatf("ar_regrant[%0d]", k), gnt1[k], 1'b1);
        m_cyc[1] = 1'b0;
        tick();

`ifdef WB_ARB_TIMEOUT_EN
        // Watchdog: m0 stalls with no ack; err pulses after TO stalled cycles and m1 follows.
        m_cyc[0] = 1'b1;
        m_stb[0] = 4'hF;
        tick();
        m_cyc[1] = 1'b1;
        for (int i = 0; i < TO; i++) begin
            for (int k = 0; k < 2; k++) check($sformatf("to_quiet[%0d]_%0d", k, i), err0[k], 1'b0);
            tick();
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("to_err0[%0d]", k), err0[k], 1'b1);
            check($sformatf("to_cyc[%0d]", k), wc[k], 1'b0);
        end
        m_cyc[0] = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("to_idle[%0d]", k), {gnt0[k], gnt1[k]}, 2'b00);
            check($sformatf("to_err_gone[%0d]", k), err0[k], 1'b0);
        end
        tick();
        for (int k = 0; k < 2; k++) check($sformatf("to_m1_gnt[%0d]", k), gnt1[k], 1'b1);
        m_cyc[1] = 1'b0;
        tick();
`endif

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            drive_random();
            tick();
        end

        quiet_inputs();
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
